// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network run controller: state encoding,
// default counter width and the epoch entry decode.
package nn_pkg;

  localparam int NN_BITS = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_STRT = 3'd1,
    ST_TRN  = 3'd2,
    ST_VAL  = 3'd3,
    ST_STOR = 3'd4,
    ST_FIN  = 3'd5
  } nn_state_e;

  // First phase of an epoch; empty phases are skipped without a pulse.
  function automatic nn_state_e epoch_entry(input logic train_nz, input logic valid_nz);
    if (train_nz) return ST_TRN;
    if (valid_nz) return ST_VAL;
    return ST_STOR;
  endfunction

endpackage

// File: rtl/nn_control_if.sv
// Link between the run FSM (master) and the per-sample slot timer (slave).
interface nn_control_if;
  // run is held high for the whole TRN/VAL phase and low otherwise; the timer
  // restarts its slot at cycle 0 whenever run is low. slot_start / slot_end are
  // combinational decodes of the slot counter and are only meaningful while run
  // is high (with a one-cycle slot both strobes are high together).
  logic run;
  logic slot_start;
  logic slot_end;

  modport master (output run, input slot_start, input slot_end);
  modport slave  (input run, output slot_start, output slot_end);
endinterface

// File: rtl/nn_slot_timer.sv
// Free-running SAMPLE_CYC-cycle slot counter, active only while run is high.
module nn_slot_timer #(
  parameter int SAMPLE_CYC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  nn_control_if.slave  tmr
);

  localparam logic [7:0] LAST = 8'(SAMPLE_CYC - 1);

  logic [7:0] r_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc <= 8'd0;
    end else if (!tmr.run || (r_cyc == LAST)) begin
      r_cyc <= 8'd0;
    end else begin
      r_cyc <= r_cyc + 8'd1;
    end
  end

  assign tmr.slot_start = tmr.run && (r_cyc == 8'd0);
  assign tmr.slot_end   = tmr.run && (r_cyc == LAST);

endmodule

// File: rtl/nn_control.sv
// Run sequencer: START, then per epoch TR/VL sample pulses on slot boundaries,
// SW at epoch end, END when all epochs are done or the run is aborted.
module nn_control
  import nn_pkg::*;
#(
  parameter int BITS       = NN_BITS,
  parameter int SAMPLE_CYC = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            go,
  input  logic            abort,
  input  logic [BITS-1:0] TRAIN,
  input  logic [BITS-1:0] VALID,
  input  logic [BITS-1:0] EPOCH,
  output logic            START,
  output logic            TR,
  output logic            VL,
  output logic            SW,
  output logic            END,
  output logic            busy,
  output logic [BITS-1:0] epoch_cnt,
  output nn_state_e       o_dbg_state
);

  nn_state_e       r_state;
  logic [BITS-1:0] r_train;
  logic [BITS-1:0] r_valid;
  logic [BITS-1:0] r_epoch;
  logic [BITS-1:0] r_smp;
  logic [BITS-1:0] r_epoch_cnt;
  logic            r_start;
  logic            r_tr;
  logic            r_vl;
  logic            r_sw;
  logic            r_end;
  logic            r_busy;

  logic [BITS-1:0] w_target;
  logic [BITS-1:0] w_smp_nxt;
  logic            w_phase_done;
  nn_state_e       w_entry;

  nn_control_if w_tmr ();

  assign w_tmr.run = (r_state == ST_TRN) || (r_state == ST_VAL);

  nn_slot_timer #(
    .SAMPLE_CYC (SAMPLE_CYC)
  ) u_slot_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tmr   (w_tmr)
  );

  // r_smp counts slots already issued in this phase; the phase ends on the
  // slot_end of the slot that brings the count up to the snapshot target.
  assign w_target     = (r_state == ST_VAL) ? r_valid : r_train;
  assign w_smp_nxt    = w_tmr.slot_start ? (r_smp + BITS'(1)) : r_smp;
  assign w_phase_done = w_tmr.slot_end && (w_smp_nxt == w_target);
  assign w_entry      = epoch_entry(r_train != '0, r_valid != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_train     <= '0;
      r_valid     <= '0;
      r_epoch     <= '0;
      r_smp       <= '0;
      r_epoch_cnt <= '0;
      r_start     <= 1'b0;
      r_tr        <= 1'b0;
      r_vl        <= 1'b0;
      r_sw        <= 1'b0;
      r_end       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_start <= 1'b0;
      r_tr    <= 1'b0;
      r_vl    <= 1'b0;
      r_sw    <= 1'b0;
      r_end   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (go) begin
            r_train     <= TRAIN;
            r_valid     <= VALID;
            r_epoch     <= EPOCH;
            r_epoch_cnt <= '0;
            r_smp       <= '0;
            r_state     <= ST_STRT;
            r_start     <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_FIN: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          // The SW pulse has already gone out, so the epoch counts even on abort.
          if (r_state == ST_STOR) r_epoch_cnt <= r_epoch_cnt + BITS'(1);
          if (abort) begin
            r_state <= ST_FIN;
            r_end   <= 1'b1;
            r_smp   <= '0;
          end else begin
            case (r_state)
              ST_STRT: begin
                if (r_epoch == '0) begin
                  r_state <= ST_FIN;
                  r_end   <= 1'b1;
                end else begin
                  r_state <= w_entry;
                  r_tr    <= (w_entry == ST_TRN);
                  r_vl    <= (w_entry == ST_VAL);
                  r_sw    <= (w_entry == ST_STOR);
                end
              end
              ST_TRN, ST_VAL: begin
                if (w_phase_done) begin
                  r_smp <= '0;
                  if ((r_state == ST_TRN) && (r_valid != '0)) begin
                    r_state <= ST_VAL;
                    r_vl    <= 1'b1;
                  end else begin
                    r_state <= ST_STOR;
                    r_sw    <= 1'b1;
                  end
                end else begin
                  r_smp <= w_smp_nxt;
                  if (w_tmr.slot_end) begin
                    r_tr <= (r_state == ST_TRN);
                    r_vl <= (r_state == ST_VAL);
                  end
                end
              end
              ST_STOR: begin
                if ((r_epoch_cnt + BITS'(1)) == r_epoch) begin
                  r_state <= ST_FIN;
                  r_end   <= 1'b1;
                end else begin
                  r_state <= w_entry;
                  r_tr    <= (w_entry == ST_TRN);
                  r_vl    <= (w_entry == ST_VAL);
                  r_sw    <= (w_entry == ST_STOR);
                end
              end
              default: r_state <= ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign START       = r_start;
  assign TR          = r_tr;
  assign VL          = r_vl;
  assign SW          = r_sw;
  assign END         = r_end;
  assign busy        = r_busy;
  assign epoch_cnt   = r_epoch_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_nn_control.sv
// Directed bench for nn_control: table of run scenarios compared as per-cycle
// pulse masks, plus hand-written mid-run reset sequence.
module tb_nn_control;
  import nn_pkg::*;

  localparam int BITS = 16;
  localparam int NCYC = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            go_a;
  logic            go_b;
  logic            abort;
  logic [BITS-1:0] train;
  logic [BITS-1:0] valid;
  logic [BITS-1:0] epoch;

  logic            start_a, tr_a, vl_a, sw_a, end_a, busy_a;
  logic [BITS-1:0] ecnt_a;
  nn_state_e       dbg_a;
  logic            start_b, tr_b, vl_b, sw_b, end_b, busy_b;
  logic [BITS-1:0] ecnt_b;
  nn_state_e       dbg_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nn_control #(.BITS(BITS), .SAMPLE_CYC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go_a), .abort(abort),
    .TRAIN(train), .VALID(valid), .EPOCH(epoch),
    .START(start_a), .TR(tr_a), .VL(vl_a), .SW(sw_a), .END(end_a),
    .busy(busy_a), .epoch_cnt(ecnt_a), .o_dbg_state(dbg_a)
  );

  nn_control #(.BITS(BITS), .SAMPLE_CYC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go_b), .abort(abort),
    .TRAIN(train), .VALID(valid), .EPOCH(epoch),
    .START(start_b), .TR(tr_b), .VL(vl_b), .SW(sw_b), .END(end_b),
    .busy(busy_b), .epoch_cnt(ecnt_b), .o_dbg_state(dbg_b)
  );

  typedef struct {
    int          train;
    int          valid;
    int          epoch;
    bit          use_b;
    int          abort_cyc;
    int          go_last;
    int          chg_cyc;
    int          chg_train;
    logic [63:0] e_start;
    logic [63:0] e_tr;
    logic [63:0] e_vl;
    logic [63:0] e_sw;
    logic [63:0] e_end;
    logic [63:0] e_busy;
    int          e_epoch;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] at(input int c);
    return 64'd1 << c;
  endfunction

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go_a  = 1'b0;
    go_b  = 1'b0;
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_a", -1, 64'({start_a, tr_a, vl_a, sw_a, end_a, busy_a, ecnt_a, dbg_a}), 64'd0);
    check("reset_b", -1, 64'({start_b, tr_b, vl_b, sw_b, end_b, busy_b, ecnt_b, dbg_b}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0]     m_start, m_tr, m_vl, m_sw, m_end, m_busy;
    logic [4:0]      p;
    logic [BITS-1:0] ep_fin;
    int              ovl;
    m_start = '0; m_tr = '0; m_vl = '0; m_sw = '0; m_end = '0; m_busy = '0;
    ovl = 0;
    do_reset();
    train = BITS'(v.train);
    valid = BITS'(v.valid);
    epoch = BITS'(v.epoch);
    for (int k = 0; k < NCYC; k++) begin
      p = v.use_b ? {start_b, tr_b, vl_b, sw_b, end_b} : {start_a, tr_a, vl_a, sw_a, end_a};
      {m_start[k], m_tr[k], m_vl[k], m_sw[k], m_end[k]} = p;
      m_busy[k] = v.use_b ? busy_b : busy_a;
      if ($countones(p) > 1) ovl++;
      if (v.use_b) go_b = (k <= v.go_last);
      else         go_a = (k <= v.go_last);
      abort = (k == v.abort_cyc);
      if ((v.chg_cyc >= 0) && (k >= v.chg_cyc)) train = BITS'(v.chg_train);
      @(posedge clk);
      @(negedge clk);
    end
    ep_fin = v.use_b ? ecnt_b : ecnt_a;
    check("start_mask", idx, m_start, v.e_start);
    check("tr_mask",    idx, m_tr,    v.e_tr);
    check("vl_mask",    idx, m_vl,    v.e_vl);
    check("sw_mask",    idx, m_sw,    v.e_sw);
    check("end_mask",   idx, m_end,   v.e_end);
    check("busy_mask",  idx, m_busy,  v.e_busy);
    check("epoch_cnt",  idx, 64'(ep_fin), 64'(v.e_epoch));
    check("pulse_overlap", idx, 64'(ovl), 64'd0);
  endtask

  initial begin
    logic [63:0] tr_ref, vl_ref, sw_ref;
    int          n_ev;
    bit          held_ok;
    tr_ref = at(2) | at(6) | at(10) | at(23) | at(27) | at(31);
    vl_ref = at(14) | at(18) | at(35) | at(39);
    sw_ref = at(22) | at(43);
    // order: train valid epoch use_b abort_cyc go_last chg_cyc chg_train
    //        start tr vl sw end busy epoch_cnt
    vecs[0] = '{3, 2, 2, 1'b0, -1, 0, -1, 0,
                at(1), tr_ref, vl_ref, sw_ref, at(44), span(1, 44), 2};
    vecs[1] = '{3, 2, 0, 1'b0, -1, 0, -1, 0,
                at(1), 64'd0, 64'd0, 64'd0, at(2), span(1, 2), 0};
    vecs[2] = '{0, 2, 1, 1'b1, -1, 0, -1, 0,
                at(1), 64'd0, at(2) | at(3), at(4), at(5), span(1, 5), 1};
    vecs[3] = '{3, 2, 2, 1'b0, 8, 0, -1, 0,
                at(1), at(2) | at(6), 64'd0, 64'd0, at(9), span(1, 9), 0};
    vecs[4] = '{3, 2, 2, 1'b0, -1, 30, 5, 7,
                at(1), tr_ref, vl_ref, sw_ref, at(44), span(1, 44), 2};

    rst_n = 1'b0; go_a = 1'b0; go_b = 1'b0; abort = 1'b0;
    train = '0; valid = '0; epoch = '0;

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset asserted in the middle of a training slot.
    do_reset();
    train = 16'd3; valid = 16'd2; epoch = 16'd2;
    for (int k = 0; k < 12; k++) begin
      go_a = (k == 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b0;
    go_a  = 1'b1;
    #1;
    check("async_reset", 0, 64'({start_a, tr_a, vl_a, sw_a, end_a, busy_a, ecnt_a, dbg_a}), 64'd0);
    held_ok = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if ({start_a, tr_a, vl_a, sw_a, end_a, busy_a} != 6'd0 || dbg_a != ST_IDLE) held_ok = 1'b0;
    end
    check("go_ignored_in_reset", 0, 64'(held_ok), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    go_a  = 1'b0;
    n_ev = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (start_a || end_a || tr_a || busy_a) n_ev++;
    end
    check("quiet_after_reset", 0, 64'(n_ev), 64'd0);
    go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0;
    check("restart_start", 0, 64'({start_a, busy_a}), 64'b11);
    @(negedge clk);
    check("restart_tr", 0, 64'({tr_a, ecnt_a}), 64'({1'b1, 16'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
